// File: rtl/light_conflict_monitor.sv
// Lamp-bus checker: encoding, exclusion, sequence, dwell, order and all-red.
// Define FAULT_COUNT_EN to add the saturating Fault_Count output.
module light_conflict_monitor #(
  parameter int GREEN_CYC  = 16,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_MAX = 2,
  parameter int CNT_W      = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] North,
  input  logic [2:0] South,
  input  logic [2:0] East,
  input  logic [2:0] West,
  input  logic       Fault_Clr,
  output logic       Fault,
  output logic       Force_Red,
  output logic [2:0] Fault_Code,
  output logic [1:0] Fault_Dir,
  output logic       Locked,
  output logic [2:0] Phase
`ifdef FAULT_COUNT_EN
  ,
  output logic [7:0] Fault_Count
`endif
);

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;
  localparam logic [CNT_W-1:0] G_N = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] Y_N = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] A_N = CNT_W'(ALLRED_MAX);

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t state, state_nx;

  logic [3:0][2:0] cur, prev_q;
  logic [CNT_W-1:0] cnt_q, ar_q;
  logic [2:0] code_q, phase_q, code_d;
  logic [1:0] dir_q, exp_q, dir_d;
  logic hit, multi, all_red;
  logic [3:0] bad_enc, nr, step_bad;
  logic [3:0] g_bad, y_bad, ord_bad, gy, on;

  function automatic logic [1:0] low4(input logic [3:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Service order N -> W -> S -> E -> N
  function automatic logic [1:0] succ(input logic [1:0] d);
    logic [1:0] r;
    unique case (d)
      2'd0:    r = 2'd3;
      2'd3:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign cur = {West, East, South, North};

  always_comb begin
    bad_enc  = '0;
    nr       = '0;
    step_bad = '0;
    g_bad    = '0;
    y_bad    = '0;
    ord_bad  = '0;
    gy       = '0;
    on       = '0;
    for (int d = 0; d < 4; d++) begin
      bad_enc[d] = !(cur[d] == RED || cur[d] == YEL
                     || cur[d] == GRN);
      nr[d] = cur[d] != RED;
      step_bad[d] =
        (prev_q[d] == GRN && cur[d] == RED) ||
        (prev_q[d] == YEL && cur[d] == GRN) ||
        (prev_q[d] == RED && cur[d] == YEL);
      g_bad[d] = prev_q[d] == GRN &&
        ((cur[d] != GRN && cnt_q != G_N) ||
         (cur[d] == GRN && cnt_q == G_N));
      y_bad[d] = prev_q[d] == YEL &&
        ((cur[d] != YEL && cnt_q != Y_N) ||
         (cur[d] == YEL && cnt_q == Y_N));
      gy[d] = prev_q[d] == GRN && cur[d] == YEL;
      on[d] = prev_q[d] == RED && cur[d] == GRN;
      ord_bad[d] = on[d] && 2'(d) != exp_q;
    end
  end

  assign multi   = (nr & (nr - 4'd1)) != 4'd0;
  assign all_red = nr == 4'd0;

  always_comb begin
    hit    = 1'b1;
    code_d = 3'd0;
    dir_d  = 2'd0;
    if (|bad_enc) begin
      code_d = 3'd1; dir_d = low4(bad_enc);
    end else if (multi) begin
      code_d = 3'd2; dir_d = low4(nr);
    end else if (state == TRACK && |step_bad) begin
      code_d = 3'd3; dir_d = low4(step_bad);
    end else if (state == TRACK && |g_bad) begin
      code_d = 3'd4; dir_d = low4(g_bad);
    end else if (state == TRACK && |y_bad) begin
      code_d = 3'd5; dir_d = low4(y_bad);
    end else if (state == TRACK && |ord_bad) begin
      code_d = 3'd6; dir_d = low4(ord_bad);
    end else if (all_red && ar_q == A_N) begin
      code_d = 3'd7;
    end else begin
      hit = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SYNC:    if (hit) state_nx = FAULT;
               else if (|gy) state_nx = TRACK;
      TRACK:   if (hit) state_nx = FAULT;
      FAULT:   if (Fault_Clr) state_nx = SYNC;
      default: state_nx = SYNC;
    endcase
  end

  always_comb begin
    Fault      = state == FAULT;
    Force_Red  = state == FAULT;
    Locked     = state == TRACK;
    Fault_Code = code_q;
    Fault_Dir  = dir_q;
    Phase      = phase_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prev_q  <= {4{RED}};
      cnt_q   <= '0;
      ar_q    <= '0;
      code_q  <= '0;
      dir_q   <= '0;
      phase_q <= '0;
      exp_q   <= '0;
    end else begin
      prev_q <= cur;
      if (state == FAULT && Fault_Clr) begin
        cnt_q  <= '0;
        ar_q   <= '0;
        code_q <= '0;
        dir_q  <= '0;
      end else begin
        if (cur != prev_q) cnt_q <= CNT_W'(1);
        else if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        if (!all_red) ar_q <= '0;
        else if (!(&ar_q)) ar_q <= ar_q + CNT_W'(1);
        if (state != FAULT && hit) begin
          code_q <= code_d;
          dir_q  <= dir_d;
        end else if (state == SYNC && |gy) begin
          phase_q <= {low4(gy), 1'b1};
          exp_q   <= succ(low4(gy));
        end else if (state == TRACK) begin
          if (|on) begin
            phase_q <= {low4(on), 1'b0};
            exp_q   <= succ(low4(on));
          end else if (|gy) begin
            phase_q <= {low4(gy), 1'b1};
          end
        end
      end
    end
  end

`ifdef FAULT_COUNT_EN
  always_ff @(posedge Clk) begin
    if (!Reset)
      Fault_Count <= '0;
    else if (state != FAULT && state_nx == FAULT
             && Fault_Count != 8'hff)
      Fault_Count <= Fault_Count + 8'd1;
  end
`endif

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
- Independent checker on the receiving end of the four-way lamp bus. It consumes the North/South/East/West 3-bit lamp codes that the intersection controller drives.
- Each cycle it checks encoding, mutual exclusion, per-direction lamp sequence, green/yellow dwell times, service order and all-red stalls.
- On the first violation it latches a fault code and direction and asserts Force_Red for the lamp override stage. It stays latched until software clears it.

Parameters:
- GREEN_CYC, 16, required green dwell in cycles.
- YELLOW_CYC, 4, required yellow dwell in cycles.
- ALLRED_MAX, 2, maximum consecutive all-red cycles tolerated.
- CNT_W, 5, dwell/all-red counter width; must hold max(GREEN_CYC, YELLOW_CYC, ALLRED_MAX)+1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- North  in  3  lamp code: 001 red, 010 yellow, 100 green.
- South  in  3  lamp code.
- East  in  3  lamp code.
- West  in  3  lamp code.
- Fault_Clr  in  1  clear request, level-sampled.
- Fault  out  1  latched fault flag.
- Force_Red  out  1  equals Fault; drives the lamp override.
- Fault_Code  out  3  first-fault cause; 0 = none.
- Fault_Dir  out  2  direction of first fault: 0 N, 1 S, 2 E, 3 W.
- Locked  out  1  high while in TRACK.
- Phase  out  3  tracked phase {dir, yellow}: N green = 000, N yellow = 001, S green = 010, …, W yellow = 111.

Behaviour:
- All checks run on inputs sampled at a rising edge, compared against the previous registered sample (prev). Fault outputs update on that same edge, i.e. they are visible one cycle after the offending value is presented.
- Reset low at any edge:
  - Fault=0, Force_Red=0, Fault_Code=0, Fault_Dir=0, Locked=0, Phase=0.
  - Counters cleared; prev = all red; state SYNC.
  - Reset overrides everything, including in the middle of a fault or a phase.
- FSM states: SYNC, TRACK, FAULT.
- SYNC:
  - Active checks: codes 1, 2, 7.
  - On the first observed green->yellow transition, enter TRACK. Expected next direction is seeded as successor(dir), with order N->W->S->E->N.
  - The partial green seen in SYNC is not dwell-checked.
- TRACK: all checks active. Phase and Locked are updated on each legal transition.
- Dwell counter: set to 1 when the lamp pattern changes, otherwise incremented and saturating at all ones.
- Fault codes; if several hit in the same cycle, the lowest code wins. Fault_Dir is the lowest-numbered offending direction.
  - 1: illegal encoding (any value other than 001/010/100).
  - 2: more than one direction not red.
  - 3: illegal lamp step. Allowed steps are green->yellow, yellow->red, red->green and hold.
  - 4: green ended with dwell != GREEN_CYC, or green dwell reached GREEN_CYC+1.
  - 5: yellow ended with dwell != YELLOW_CYC, or yellow dwell reached YELLOW_CYC+1.
  - 6: red->green onset in a direction other than the expected one.
  - 7: all four red for ALLRED_MAX+1 consecutive cycles.
- A direct yellow(d)->green(next) handover on the same edge is legal and counts as 0 all-red cycles.
- Any fault in SYNC or TRACK: enter FAULT. Fault=Force_Red=1; code and direction are latched and frozen; Locked=0.
- FAULT: further violations are ignored. Fault_Clr=1 at an edge returns to SYNC with Fault/Code/Dir cleared and counters cleared.
- Fault_Clr in SYNC or TRACK is ignored. A fault detected on the same edge as Fault_Clr while in TRACK is still latched.

Optional Feature:
- Macro FAULT_COUNT_EN.
- Defined: adds output Fault_Count[7:0]. It increments on each entry to FAULT, saturates at 255, is cleared only by Reset (not by Fault_Clr), and its reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Legal stream for 3 full rounds (N green 16 / N yellow 4 / W green 16 / W yellow 4 / S / E) from reset -> Fault=0 throughout; Locked=1 from the edge after the first N green->yellow; Phase steps 001,110,111,010,011,100,101,000.
- In TRACK, present North=3'b011 for one cycle -> next edge Fault=1, Force_Red=1, Fault_Code=1, Fault_Dir=0.
- North=100 and East=100 in the same cycle -> Fault_Code=2, Fault_Dir=0. Also, W green held 17 cycles -> Fault_Code=4, Fault_Dir=3 on the 17th-sample edge.
- After W yellow ends, drive East green instead of South -> Fault_Code=6, Fault_Dir=2. Separately, all red for 3 cycles -> Fault_Code=7.
- Fault latched, then a second violation, then Fault_Clr=1 -> code unchanged until the clear; after the clear Fault=0, Locked=0, and the monitor re-locks on the next green->yellow. With FAULT_COUNT_EN, Fault_Count=1 after the first fault and 2 after a second.
- Reset low mid-green with Fault=1 -> next edge all outputs 0, state SYNC; a stray red->green right after reset gives no code 6.
